// File: rtl/mult_pkg.sv
// Shared types and constants for the shared-multiplier scheduler.
// Controller states and the operand/product widths of the attached multiplier.
package mult_pkg;

    localparam int unsigned MULT_W       = 8;
    localparam int unsigned PROD_W       = 16;
    localparam int unsigned MULT_LAT_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or
// above i_ptr, wrapping past N-1, as a one-hot vector plus its index.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            w_idx = IW'((32'(i_ptr) + k) % N);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_idx          = w_idx;
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier between N_REQ
// requesters; parks the multiplier in reset except for one computation at a time.
module mult_sched
    import mult_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [MULT_W*N_REQ-1:0]     req_a,
    input  logic [MULT_W*N_REQ-1:0]     req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        resp_valid,
    output logic [$clog2(N_REQ)-1:0]    resp_id,
    output logic [PROD_W-1:0]           resp_data,
    input  logic                        resp_ready,
    output logic                        busy,
    output logic                        mult_rst,
    output logic [MULT_W-1:0]           mult_in1,
    output logic [MULT_W-1:0]           mult_in2,
    input  logic [PROD_W-1:0]           mult_out
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned CW  = $clog2(MULT_LAT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [IDW-1:0]      r_ptr;
    logic [IDW-1:0]      r_id;
    logic [CW-1:0]       r_cnt;
    logic [MULT_W-1:0]   r_a;
    logic [MULT_W-1:0]   r_b;
    logic [PROD_W-1:0]   r_data;

    logic [N_REQ-1:0]    w_grant;
    logic [IDW-1:0]      w_gnt_idx;
    logic                w_any;
    logic [MULT_W-1:0]   w_sel_a;
    logic [MULT_W-1:0]   w_sel_b;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDW)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gnt_idx),
        .o_any   (w_any)
    );

    assign w_sel_a = req_a[int'(w_gnt_idx)*MULT_W +: MULT_W];
    assign w_sel_b = req_b[int'(w_gnt_idx)*MULT_W +: MULT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // mult_rst is decoded from state so an async reset re-parks the multiplier at once.
    always_comb begin
        w_next     = r_state;
        req_ready  = '0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        mult_rst   = 1'b0;
        case (r_state)
            IDLE: begin
                busy      = 1'b0;
                mult_rst  = 1'b1;
                req_ready = rst_n ? w_grant : '0;
                if (w_any) w_next = LOAD;
            end
            LOAD: w_next = RUN;
            RUN: begin
                if (r_cnt == CW'(MULT_LAT)) w_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                mult_rst   = 1'b1;
                if (resp_ready) w_next = IDLE;
            end
            default: begin
                w_next   = IDLE;
                mult_rst = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_cnt  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_a  <= w_sel_a;
                        r_b  <= w_sel_b;
                        r_id <= w_gnt_idx;
                        if (w_gnt_idx == IDW'(N_REQ - 1)) r_ptr <= '0;
                        else                              r_ptr <= w_gnt_idx + 1'b1;
                    end
                end
                LOAD: r_cnt <= CW'(1);
                RUN: begin
                    if (r_cnt == CW'(MULT_LAT)) r_data <= mult_out;
                    else                        r_cnt  <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_id   = r_id;
    assign resp_data = r_data;
    assign mult_in1  = r_a;
    assign mult_in2  = r_b;

endmodule

// File: tb/tb_mult_sched.sv
// Self-checking bench for mult_sched: shift-add multiplier plant, round-robin
// reference model, directed scenarios followed by randomized traffic.
module tb_mult_sched;

    localparam int N   = 4;
    localparam int LAT = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_a = '0;
    logic [8*N-1:0]   req_b = '0;
    logic [N-1:0]     req_ready;
    logic             resp_valid;
    logic [1:0]       resp_id;
    logic [15:0]      resp_data;
    logic             resp_ready = 1'b1;
    logic             busy;
    logic             mult_rst;
    logic [7:0]       mult_in1;
    logic [7:0]       mult_in2;
    logic [15:0]      mult_out;

    always #5 clk = ~clk;

    mult_sched #(
        .N_REQ    (N),
        .MULT_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .busy       (busy),
        .mult_rst   (mult_rst),
        .mult_in1   (mult_in1),
        .mult_in2   (mult_in2),
        .mult_out   (mult_out)
    );

    // Multiplier plant: stage 0 samples operands, stages 1..8 add partial products.
    logic [3:0]  m_stage = '0;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;
    logic [15:0] m_acc = '0;

    always @(posedge clk) begin
        if (mult_rst) begin
            m_stage <= '0;
            m_acc   <= '0;
        end else if (m_stage == 0) begin
            m_a     <= mult_in1;
            m_b     <= mult_in2;
            m_acc   <= '0;
            m_stage <= 4'd1;
        end else if (m_stage <= 8) begin
            if (m_b[m_stage-1]) m_acc <= m_acc + (16'(m_a) << (m_stage - 1));
            m_stage <= m_stage + 4'd1;
        end else begin
            m_stage <= '0;
        end
    end
    assign mult_out = m_acc;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [N-1:0] vld = '0;
    logic [N-1:0] ghost = '0;
    logic [7:0]   opa [N];
    logic [7:0]   opb [N];
    int           ptr = 0;
    int           last_grant_cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = vld[i] | ghost[i];
            req_a[i*8 +: 8]    = opa[i];
            req_b[i*8 +: 8]    = opb[i];
        end
    endtask

    function automatic int model_pick();
        for (int k = 0; k < N; k++) begin
            if (vld[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic serve_one(input int stall, input int exp_gap, input logic [N-1:0] ghost_mask);
        int          id;
        int          lat;
        int          waited;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        resp_ready = (stall == 0);
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check_eq("grant_seen", 32'(|req_ready), 1);
        if (req_ready == '0) return;
        id = model_pick();
        check_eq("grant_onehot", 32'(req_ready), 32'(1 << id));
        check_eq("idle_mult_rst", 32'(mult_rst), 1);
        check_eq("idle_busy", 32'(busy), 0);
        if (exp_gap > 0) check_eq("issue_gap", 32'(cyc - last_grant_cyc), 32'(exp_gap));
        last_grant_cyc = cyc;
        a    = opa[id];
        b    = opb[id];
        prod = 16'(a) * 16'(b);
        ptr  = (id + 1) % N;
        @(negedge clk);
        vld[id] = 1'b0;
        drive();
        lat = 1;
        while (!resp_valid && lat < 40) begin
            if (lat == 3) begin ghost = ghost_mask; drive(); #1; end
            if (lat == 6) begin ghost = '0; drive(); #1; end
            check_eq("run_busy", 32'(busy), 1);
            check_eq("run_mult_rst", 32'(mult_rst), 0);
            check_eq("run_in1", 32'(mult_in1), 32'(a));
            check_eq("run_in2", 32'(mult_in2), 32'(b));
            check_eq("run_ready", 32'(req_ready), 0);
            @(negedge clk);
            lat++;
        end
        check_eq("resp_latency", 32'(lat), 32'(LAT + 2));
        check_eq("resp_data", 32'(resp_data), 32'(prod));
        check_eq("resp_id", 32'(resp_id), 32'(id));
        check_eq("resp_mult_rst", 32'(mult_rst), 1);
        repeat (stall) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(resp_valid), 1);
            check_eq("stall_data", 32'(resp_data), 32'(prod));
            check_eq("stall_ready", 32'(req_ready), 0);
            check_eq("stall_mult_rst", 32'(mult_rst), 1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_eq("resp_done", 32'(resp_valid), 0);
    endtask

    task automatic post(input int i, input logic [7:0] a, input logic [7:0] b);
        vld[i] = 1'b1;
        opa[i] = a;
        opb[i] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        drive();
        repeat (2) @(negedge clk);
        check_eq("rst_resp_valid", 32'(resp_valid), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_mult_rst", 32'(mult_rst), 1);
        check_eq("rst_req_ready", 32'(req_ready), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 13*11 from requester 0
        post(0, 8'd13, 8'd11); drive();
        serve_one(0, 0, '0);

        // 255*255, with requester 2 pulsing valid and dropping it before a grant
        post(1, 8'd255, 8'd255); drive();
        serve_one(0, 0, 4'b0100);

        // 0*200 stalled for 20 cycles while requester 3 waits
        post(2, 8'd0, 8'd200); post(3, 8'd77, 8'd3); drive();
        serve_one(20, 0, '0);
        serve_one(0, 0, '0);

        // All four held, two passes
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < N; i++) post(i, 8'(10 * pass + i + 2), 8'(200 - i));
            drive();
            for (int i = 0; i < N; i++) serve_one(0, (pass == 0 && i == 0) ? 0 : 12, '0);
        end

        // Reset while RUN cnt=5
        post(0, 8'd7, 8'd9); drive();
        #1;
        waited = 0;
        while (req_ready == '0 && waited < 50) begin @(negedge clk); waited++; end
        check_eq("rst_test_grant", 32'(req_ready), 32'(1 << model_pick()));
        @(negedge clk);
        vld[0] = 1'b0; drive();
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrun_busy", 32'(busy), 0);
        check_eq("midrun_mult_rst", 32'(mult_rst), 1);
        check_eq("midrun_resp_valid", 32'(resp_valid), 0);
        ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) begin
            @(negedge clk);
            check_eq("post_rst_no_resp", 32'(resp_valid), 0);
            check_eq("post_rst_idle", 32'(busy), 0);
        end

        // 3*5 from requester 3 after reset
        post(3, 8'd3, 8'd5); drive();
        serve_one(0, 0, '0);

        // Randomized traffic
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!vld[i] && $urandom_range(0, 1) == 1) begin
                    case ($urandom_range(0, 3))
                        0:       post(i, 8'd255, 8'($urandom));
                        1:       post(i, 8'($urandom), 8'd0);
                        default: post(i, 8'($urandom), 8'($urandom));
                    endcase
                end
            end
            if (vld == '0) post(int'($urandom_range(0, N - 1)), 8'($urandom), 8'($urandom));
            drive();
            serve_one(int'($urandom_range(0, 3)), 0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
